serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial N-bit adder built around a single full_adder instance plus a carry flip-flop.
//   Sits directly downstream of the full_adder cell: loads two WIDTH-bit operands and a carry-in.
//   Feeds one bit per cycle, LSB first, through the full_adder and collects the sum bits.
//   Valid/ready handshakes on both sides give the area-cheap adder used where latency is acceptable.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range WIDTH >= 1
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands and cin are valid this cycle
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a_in       in   WIDTH  operand A
//   b_in       in   WIDTH  operand B
//   cin        in   1      carry-in
//   out_valid  out  1      sum/cout hold a completed result
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  a_in + b_in + cin, low WIDTH bits
//   cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   Reset: state=IDLE; out_valid=0, sum=0, cout=0; internal regs and bit counter cleared.
//   - in_ready=1 from the first cycle after reset.
//   FSM (3 states):
//   - IDLE: in_ready=1. On in_valid&&in_ready: A<=a_in, B<=b_in, carry<=cin, S<=0, cnt<=0 -> RUN.
//   - RUN: in_ready=0; the full_adder sees (A[0], B[0], carry). Each edge:
//     - S <= {fa_sum, S[WIDTH-1:1]}; A,B shift right by 1; carry <= fa_cout; cnt <= cnt+1.
//     - When cnt==WIDTH-1 on that edge -> DONE.
//   - DONE: out_valid=1; sum=S, cout=carry, held stable while out_ready=0.
//     - On out_ready=1 -> IDLE; out_valid drops on the same edge.
//   Latency: handshake edge E0; RUN occupies edges E1..EWIDTH; out_valid=1 after EWIDTH.
//   Throughput: at most one operation per WIDTH+2 cycles. in_ready is 0 in DONE, so no same-cycle reload.
//   in_valid, a_in, b_in and cin are ignored outside IDLE; no second operation is queued.
//   out_ready is ignored unless out_valid=1.
//   cnt is $clog2(WIDTH+1) bits wide, so WIDTH=1 works: exactly one RUN cycle.
//   Arithmetic: {cout,sum} == a_in + b_in + cin, exact over WIDTH+1 bits, no saturation.
//   Wrap-around: an all-ones sum plus carry gives sum=0, cout=1.
//   rst in any state (including mid-RUN or DONE awaiting out_ready) aborts the operation:
//   - next cycle IDLE, out_valid=0, sum=0, cout=0; the partial result is discarded.
//   sum/cout are registered outputs; in_ready/out_valid decode from registered state only.
// TESTING  (WIDTH=8 unless noted; outputs sampled on the cycle out_valid=1)
//   1. a=8'h00, b=8'h00, cin=0 -> out_valid exactly 8 cycles after accept; sum=8'h00, cout=0.
//   2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple through all bits).
//   3. a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
//      Then a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0 (back-to-back).
//   4. Backpressure, a=8'h12, b=8'h34, cin=0, out_ready low 5 cycles:
//      - sum=8'h46, cout=0, out_valid held stable throughout; completes on the out_ready edge.
//      - in_valid pulsed with new data during RUN/DONE is ignored; in_ready stays 0.
//   5. rst asserted on the 3rd RUN cycle -> next cycle out_valid=0, sum=0, in_ready=1.
//      - A new op 8'h80+8'h80, cin=0 then returns sum=8'h00, cout=1.
//   6. WIDTH=1 exhaustive 8 combos and WIDTH=8 1000 random ops:
//      - {cout,sum} == a+b+cin every time; out_valid 1 cycle after accept for WIDTH=1.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: operand side (in_*),
// result side (out_*, sum, cout).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Producer/consumer environment around the adder
  modport master (
    output in_valid, a_in, b_in, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // The adder itself
  modport slave (
    input  in_valid, a_in, b_in, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flip-flop,
// fed one operand bit per cycle LSB first, with valid/ready on both sides.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  // Counter must hold WIDTH-1, and stays at least 1 bit wide for WIDTH=1
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] s_shift;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             in_ready;
  logic             out_valid;

  // The only arithmetic in the block: one bit position per cycle
  full_adder u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .ci (carry),
    .s  (fa_sum),
    .co (fa_cout)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at S[0]
  if (WIDTH == 1) begin : g_one_bit
    assign s_shift = fa_sum;
  end else begin : g_multi_bit
    assign s_shift = {fa_sum, s_reg[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: accept in IDLE, run WIDTH bit cycles, hold result until taken
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (cnt == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode purely from the registered state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a_in;
            b_reg <= bus.b_in;
            carry <= bus.cin;
            s_reg <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          s_reg <= s_shift;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = s_reg;
  assign bus.cout      = carry;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  localparam int MAX_WAIT = 40;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.a_in     = a;
    bus8.b_in     = b;
    bus8.cin      = c;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
  endtask

  task automatic release8();
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  task automatic start1(input logic a, input logic b, input logic c);
    bus1.a_in     = a;
    bus1.b_in     = b;
    bus1.cin      = c;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_done1(output int lat);
    lat = 0;
    while (bus1.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
  endtask

  task automatic release1();
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus8.out_valid); end
    total++; if (bus8.sum !== 8'h00) begin bad++; $display("[TB] FAIL reset_sum: got %h want 00", bus8.sum); end
    total++; if (bus8.cout !== 1'b0) begin bad++; $display("[TB] FAIL reset_cout: got %b want 0", bus8.cout); end
    rst = 1'b0;
    tick();
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
    total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_w1: got %b want 1", bus1.in_ready); end
    total++; if (bus1.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid_w1: got %b want 0", bus1.out_valid); end
  endtask

  task automatic test_zero();
    int lat;
    start8(8'h00, 8'h00, 1'b0);
    wait_done8(lat);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL zero_latency: got %0d want 8", lat); end
    total++; if (bus8.sum !== 8'h00) begin bad++; $display("[TB] FAIL zero_sum: got %h want 00", bus8.sum); end
    total++; if (bus8.cout !== 1'b0) begin bad++; $display("[TB] FAIL zero_cout: got %b want 0", bus8.cout); end
    release8();
    total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL zero_release: got %b want 0", bus8.out_valid); end
  endtask

  task automatic test_ripple();
    int lat;
    start8(8'hFF, 8'h01, 1'b0);
    wait_done8(lat);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL ripple_latency: got %0d want 8", lat); end
    total++; if (bus8.sum !== 8'h00) begin bad++; $display("[TB] FAIL ripple_sum: got %h want 00", bus8.sum); end
    total++; if (bus8.cout !== 1'b1) begin bad++; $display("[TB] FAIL ripple_cout: got %b want 1", bus8.cout); end
    release8();
  endtask

  task automatic test_back_to_back();
    int lat;
    start8(8'hA5, 8'h5A, 1'b1);
    wait_done8(lat);
    total++; if (bus8.sum !== 8'h00) begin bad++; $display("[TB] FAIL b2b_first_sum: got %h want 00", bus8.sum); end
    total++; if (bus8.cout !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first_cout: got %b want 1", bus8.cout); end
    total++; if (bus8.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_in_ready_done: got %b want 0", bus8.in_ready); end
    release8();
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready_idle: got %b want 1", bus8.in_ready); end
    start8(8'h3C, 8'h0F, 1'b0);
    wait_done8(lat);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL b2b_second_latency: got %0d want 8", lat); end
    total++; if (bus8.sum !== 8'h4B) begin bad++; $display("[TB] FAIL b2b_second_sum: got %h want 4b", bus8.sum); end
    total++; if (bus8.cout !== 1'b0) begin bad++; $display("[TB] FAIL b2b_second_cout: got %b want 0", bus8.cout); end
    release8();
  endtask

  task automatic test_backpressure();
    int lat;
    start8(8'h12, 8'h34, 1'b0);
    bus8.a_in     = 8'hFF;
    bus8.b_in     = 8'hFF;
    bus8.cin      = 1'b1;
    bus8.in_valid = 1'b1;
    total++; if (bus8.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready_run: got %b want 0", bus8.in_ready); end
    wait_done8(lat);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL bp_latency: got %0d want 8", lat); end
    total++; if (bus8.sum !== 8'h46) begin bad++; $display("[TB] FAIL bp_sum: got %h want 46", bus8.sum); end
    total++; if (bus8.cout !== 1'b0) begin bad++; $display("[TB] FAIL bp_cout: got %b want 0", bus8.cout); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus8.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b want 1", i, bus8.out_valid); end
      total++; if (bus8.sum !== 8'h46) begin bad++; $display("[TB] FAIL bp_hold_sum[%0d]: got %h want 46", i, bus8.sum); end
      total++; if (bus8.cout !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_cout[%0d]: got %b want 0", i, bus8.cout); end
      total++; if (bus8.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_in_ready[%0d]: got %b want 0", i, bus8.in_ready); end
    end
    bus8.in_valid = 1'b0;
    release8();
    total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid: got %b want 0", bus8.out_valid); end
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_in_ready: got %b want 1", bus8.in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start8(8'h77, 8'h11, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++; if (bus8.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_out_valid: got %b want 0", bus8.out_valid); end
    total++; if (bus8.sum !== 8'h00) begin bad++; $display("[TB] FAIL abort_sum: got %h want 00", bus8.sum); end
    total++; if (bus8.cout !== 1'b0) begin bad++; $display("[TB] FAIL abort_cout: got %b want 0", bus8.cout); end
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_ready: got %b want 1", bus8.in_ready); end
    rst = 1'b0;
    start8(8'h80, 8'h80, 1'b0);
    wait_done8(lat);
    total++; if (lat !== 8) begin bad++; $display("[TB] FAIL abort_next_latency: got %0d want 8", lat); end
    total++; if (bus8.sum !== 8'h00) begin bad++; $display("[TB] FAIL abort_next_sum: got %h want 00", bus8.sum); end
    total++; if (bus8.cout !== 1'b1) begin bad++; $display("[TB] FAIL abort_next_cout: got %b want 1", bus8.cout); end
    release8();
  endtask

  task automatic test_width1();
    int         lat;
    logic [1:0] exp;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v   = 3'(i);
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      start1(v[2], v[1], v[0]);
      wait_done1(lat);
      total++; if (lat !== 1) begin bad++; $display("[TB] FAIL w1_latency[%0d]: got %0d want 1", i, lat); end
      total++; if ({bus1.cout, bus1.sum} !== exp) begin bad++; $display("[TB] FAIL w1_result[%0d]: got %b want %b", i, {bus1.cout, bus1.sum}, exp); end
      release1();
    end
  endtask

  task automatic test_random();
    int         lat;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      c   = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + 9'(c);
      start8(a, b, c);
      wait_done8(lat);
      total++; if (lat !== 8) begin bad++; $display("[TB] FAIL rand_latency[%0d]: got %0d want 8", i, lat); end
      total++; if ({bus8.cout, bus8.sum} !== exp) begin bad++; $display("[TB] FAIL rand_result[%0d] %h+%h+%b: got %h want %h", i, a, b, c, {bus8.cout, bus8.sum}, exp); end
      release8();
    end
  endtask

  // Sequence the scenarios and print the summary
  initial begin
    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a_in      = '0;
    bus8.b_in      = '0;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a_in      = '0;
    bus1.b_in      = '0;
    bus1.cin       = 1'b0;
    bus1.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_width1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
